// File: rtl/wb_port_arbiter.sv
// Writeback port arbiter: shares the regfile write port between the ALU and the LSU
// with round-robin on contention, and keeps a pending-destination scoreboard for decode.
module wb_port_arbiter #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_valid,
  input  logic [4:0]       iss_rd,
  output logic             iss_stall,
  input  logic [4:0]       rn1,
  input  logic [4:0]       rn2,
  output logic             busy1,
  output logic             busy2,
  input  logic             req0_valid,
  input  logic [4:0]       req0_rd,
  input  logic [XLEN-1:0]  req0_wd,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [4:0]       req1_rd,
  input  logic [XLEN-1:0]  req1_wd,
  output logic             req1_ready,
  output logic             we,
  output logic [4:0]       wn,
  output logic [XLEN-1:0]  wd,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {
    PREF_ALU = 1'b0,
    PREF_LSU = 1'b1
  } pref_t;

  pref_t            rr_ptr;
  logic [31:0]      pending;
  logic [31:0]      pending_nxt;
  logic             both_valid;
  logic             grant_any;
  logic [4:0]       grant_rd;
  logic [XLEN-1:0]  grant_wd;
  logic             iss_set;

  assign both_valid = req0_valid && req1_valid;

  // Ready is a pure function of the valids and rr_ptr, so a requester may not
  // wait on its own ready before asserting valid.
  assign req0_ready = req0_valid && (!req1_valid || (rr_ptr == PREF_ALU));
  assign req1_ready = req1_valid && (!req0_valid || (rr_ptr == PREF_LSU));

  assign grant_any = req0_ready || req1_ready;
  assign grant_rd  = req1_ready ? req1_rd : req0_rd;
  assign grant_wd  = req1_ready ? req1_wd : req0_wd;

  assign iss_stall = iss_valid && pending[iss_rd];
  assign iss_set   = iss_valid && !iss_stall && (iss_rd != 5'd0);
  assign busy1     = (rn1 != 5'd0) && pending[rn1];
  assign busy2     = (rn2 != 5'd0) && pending[rn2];

  always_comb begin
    // NOTE: default assignment first so every path drives pending_nxt (no latch).
    pending_nxt = pending;
    if (grant_any) pending_nxt[grant_rd] = 1'b0;
    // Issue is applied after the clear so a same-index set wins.
    if (iss_set) pending_nxt[iss_rd] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only.
      pending      <= '0;
      we           <= 1'b0;
      wn           <= '0;
      wd           <= '0;
      rr_ptr       <= PREF_ALU;
      conflict_cnt <= '0;
    end else begin
      pending <= pending_nxt;
      we      <= grant_any && (grant_rd != 5'd0);
      if (grant_any) begin
        wn <= grant_rd;
        wd <= grant_wd;
      end
      if (both_valid) begin
        rr_ptr <= (rr_ptr == PREF_ALU) ? PREF_LSU : PREF_ALU;
        if (conflict_cnt != '1) conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule
